alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's single-cycle 32-bit ALU. Adds WIDTH generalisation, an 8-entry opcode space (logic, add/sub, signed compare, iterative multiply), registered results with registered flags, and valid/ready flow control on both sides. Sits between the operand-fetch stage and writeback. The block holds exactly one operation in flight.

## Interface
- WIDTH, default 32: operand and result width; must be at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept an operation; combinational, equal to (state == IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  3  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carry, zero, negative, overflow  out  1 each  registered flags.

## Operation
Opcodes:
- 000 AND.
- 001 ADD.
- 010 SUB.
- 011 OR.
- 100 XOR.
- 101 SLT: result = 1 if signed a < signed b, else 0.
- 110 MUL: unsigned; result = low WIDTH bits of the product.
- 111 reserved: result = 0.

Flags:
- ADD: carry = carry out of the MSB; overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]).
- SUB: carry = borrow, i.e. unsigned a < b; overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
- MUL: carry = OR of the upper WIDTH product bits; overflow = 0.
- All other opcodes: carry = 0, overflow = 0.
- All opcodes: zero = (result == 0); negative = result[MSB].

State machine:
- IDLE: an accept happens when in_valid && in_ready.
  - On accept of opcode 110: latch a and b, clear the accumulator, go to MUL.
  - On accept of any other opcode: compute combinationally, register result and flags, go to DONE.
- MUL: one shift-add step per cycle using an internal counter that runs 0..WIDTH-1. When the counter reaches WIDTH-1, register result and flags and go to DONE.
- DONE: out_valid = 1. On out_ready, go to IDLE. result and flags hold until the next result is registered.

Boundary conditions:
- in_valid while busy: ignored, because in_ready = 0. The upstream stage must hold its operands until accepted.
- out_ready held high continuously: throughput is one operation per 2 cycles for single-cycle ops and one per WIDTH+2 cycles for MUL.
- out_ready low in DONE: the block stalls indefinitely with result held stable.
- rst asserted mid-MUL or in DONE: the operation is aborted, no output is produced, and the block returns to the reset state.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, all flags = 0, counter = 0.
- Latency, single-cycle ops: accept on edge N gives out_valid = 1 after edge N.
- Latency, MUL: accept on edge N gives out_valid = 1 after edge N+WIDTH.
- out_valid falls on the edge where out_ready is sampled high in DONE.
- in_ready rises in that same cycle, because the state is then IDLE.
- No combinational path from any input to any output except state to in_ready.

## Configuration
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL state, multiplier datapath and counter are compiled in; opcode 110 behaves as above.
- Undefined: opcode 110 is treated as reserved. It takes the single-cycle path with result = 0 and zero = 1, and no MUL state exists.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams OP_AND, OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_SLT, OP_MUL, OP_RSV;
  - state encoding typedef alu_state_t with values IDLE, MUL, DONE.
- Sub-module alu_mul_iter, present only under ALU_SEQ_MUL_EN:
  - start/done iterative shift-add unsigned multiplier;
  - outputs a 2*WIDTH product.
- The top level owns the FSM, the single-cycle datapath and the flag generation.

## Test plan
All scenarios use WIDTH=32.
- ADD a=10, b=15 → result 25, all flags 0, out_valid one cycle after accept.
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, overflow=1, negative=1, carry=0. ADD a=0xFFFFFFFF, b=1 → result 0, carry=1, zero=1.
- SUB a=10, b=20 → result 0xFFFFFFF6, carry=1, negative=1, overflow=0. SLT a=-1, b=1 → result 1.
- MUL a=0x10000, b=0x10000 → result 0, carry=1, zero=1, out_valid 32 cycles after accept. Without ALU_SEQ_MUL_EN, opcode 110 → result 0, latency 1.
- Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle.
- Assert rst 10 cycles into a MUL → immediately in_ready=1, out_valid=0, result=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcode encodings and FSM state type for alu_seq.
//               The MUL state exists only when ALU_SEQ_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } alu_state_t;
`endif

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add unsigned multiplier, one multiplier bit
//               per cycle. start latches the operands; done pulses in the
//               cycle of the last step, with product already including it.
//               Compiled only when ALU_SEQ_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] w_sum;

    // Accumulate the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        w_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = w_sum;
            if (cnt_q == c_CNT_LAST) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Multiplier datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done    = busy_q && (cnt_q == c_CNT_LAST);
    assign product = w_sum;

endmodule : alu_mul_iter
`endif
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked single-operation ALU with registered result and
//               flags. Optional iterative multiply enabled by the macro
//               ALU_SEQ_MUL_EN; without it opcode 110 acts as reserved.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic             w_is_mul;

`ifdef ALU_SEQ_MUL_EN
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`endif

    // Single-cycle datapath: result and carry/overflow for every non-MUL opcode
    always_comb begin
        w_sum        = {1'b0, a} + {1'b0, b};
        w_diff       = a - b;
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        case (opcode)
            OP_AND: w_alu_result = a & b;
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                w_alu_carry  = (a < b);
                w_alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  w_alu_result = a | b;
            OP_XOR: w_alu_result = a ^ b;
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: w_alu_result = '0;
            OP_RSV: w_alu_result = '0;
            default: w_alu_result = '0;
        endcase
    end

    // Next-state, result and flag selection for the IDLE/MUL/DONE controller
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
`ifdef ALU_SEQ_MUL_EN
        w_mul_start = 1'b0;
        w_is_mul    = (opcode == OP_MUL);
`else
        w_is_mul    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (w_is_mul) begin
`ifdef ALU_SEQ_MUL_EN
                        w_mul_start = 1'b1;
                        state_d     = MUL;
`endif
                    end else begin
                        result_d    = w_alu_result;
                        carry_d     = w_alu_carry;
                        overflow_d  = w_alu_ovf;
                        zero_d      = (w_alu_result == '0);
                        negative_d  = w_alu_result[WIDTH-1];
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (w_mul_done) begin
                    result_d    = w_mul_product[WIDTH-1:0];
                    carry_d     = |w_mul_product[2*WIDTH-1:WIDTH];
                    overflow_d  = 1'b0;
                    zero_d      = (w_mul_product[WIDTH-1:0] == '0);
                    negative_d  = w_mul_product[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Controller state plus registered result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq at WIDTH=32.
//               Covers the MUL path when ALU_SEQ_MUL_EN is defined and the
//               reserved treatment of opcode 110 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, carry, zero, negative, overflow;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    assign flags = {carry, zero, negative, overflow};

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Present one operation for a single edge; caller is 1 ns after an edge in IDLE
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        rst = 1'b0;
    endtask

    // flags are {carry, zero, negative, overflow}
    task automatic test_single_cycle();
        logic [2:0]  ops  [11] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                                   3'b011, 3'b100, 3'b101, 3'b101, 3'b111};
        logic [31:0] va   [11] = '{32'hF0F0F0F0, 32'd10, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd10, 32'h80000000,
                                   32'h0F0F0000, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'd1, 32'd5};
        logic [31:0] vb   [11] = '{32'hFF00FF00, 32'd15, 32'd1, 32'd1, 32'd20, 32'd1,
                                   32'h000000FF, 32'hAAAAAAAA, 32'd1, 32'hFFFFFFFF, 32'd7};
        logic [31:0] er   [11] = '{32'hF000F000, 32'd25, 32'h80000000, 32'h0, 32'hFFFFFFF6, 32'h7FFFFFFF,
                                   32'h0F0F00FF, 32'h0, 32'd1, 32'd0, 32'd0};
        logic [3:0]  ef   [11] = '{4'b0010, 4'b0000, 4'b0011, 4'b1100, 4'b1010, 4'b0001,
                                   4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        for (int i = 0; i < 11; i++) begin
            issue(ops[i], va[i], vb[i]);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_latency: out_valid got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL op%0d_in_ready: got %b expected 0", i, in_ready); end
            checks++; if (result !== er[i]) begin errors++; $display("FAIL op%0d_result: got %h expected %h", i, result, er[i]); end
            checks++; if (flags !== ef[i]) begin errors++; $display("FAIL op%0d_flags: got %b expected %b", i, flags, ef[i]); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
                $display("FAIL op%0d_release: out_valid/in_ready got %b%b expected 01", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
        logic [31:0] va [4] = '{32'h00010000, 32'hFFFFFFFF, 32'd3,  32'h12345678};
        logic [31:0] vb [4] = '{32'h00010000, 32'hFFFFFFFF, 32'd5,  32'h00000010};
        logic [31:0] er [4] = '{32'h0,        32'h1,        32'd15, 32'h23456780};
        logic [3:0]  ef [4] = '{4'b1100,      4'b1000,      4'b0000, 4'b1000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(3'b110, va[i], vb[i]);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul%0d_busy: in_ready got %b expected 0", i, in_ready); end
            lat = 0;
            while (out_valid !== 1'b1 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (lat != 32) begin errors++; $display("FAIL mul%0d_latency: got %0d expected 32", i, lat); end
            checks++; if (result !== er[i]) begin errors++; $display("FAIL mul%0d_result: got %h expected %h", i, result, er[i]); end
            checks++; if (flags !== ef[i]) begin errors++; $display("FAIL mul%0d_flags: got %b expected %b", i, flags, ef[i]); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
`else
        issue(3'b110, 32'h00010000, 32'h00010000);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_rsv_latency: out_valid got %b expected 1", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL mul_rsv_result: got %h expected 0", result); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL mul_rsv_flags: got %b expected 0100", flags); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`endif
    endtask

    task automatic test_stall();
        issue(3'b001, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            opcode = 3'b010; a = 32'd100; b = 32'd1; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
                $display("FAIL stall%0d_handshake: out_valid/in_ready got %b%b expected 10", i, out_valid, in_ready); end
            checks++; if (result !== 32'd7) begin errors++; $display("FAIL stall%0d_result: got %h expected 7", i, result); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release: out_valid/in_ready got %b%b expected 01", out_valid, in_ready); end
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL stall_hold: got %h expected 7", result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_ignored: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        opcode = 3'b001; a = 32'd1; b = 32'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== ((i % 2) == 0)) begin errors++;
                $display("FAIL b2b%0d_out_valid: got %b expected %b", i, out_valid, ((i % 2) == 0)); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (result !== 32'd3) begin errors++; $display("FAIL b2b_result: got %h expected 3", result); end
    endtask

    task automatic test_reset_abort();
        int stale;
        issue(3'b100, 32'h00001234, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_done_setup: out_valid got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL abort_done_handshake: in_ready/out_valid got %b%b expected 10", in_ready, out_valid); end
        checks++; if (result !== 32'h0 || flags !== 4'b0000) begin errors++;
            $display("FAIL abort_done_result: got %h/%b expected 0/0000", result, flags); end
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        issue(3'b110, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin errors++;
            $display("FAIL abort_mul: in_ready/out_valid/result got %b%b/%h expected 10/0", in_ready, out_valid, result); end
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        out_ready = 1'b0;
        checks++; if (stale != 0) begin errors++; $display("FAIL abort_stale: got %0d valid cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
